// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR low-pass filter with one shared pre-adder/multiplier.
// Each accepted sample is shifted into its channel's delay line, then NPAIR coefficient pairs are accumulated.
module fir_sym_mc #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int NTAPS     = 22,
    parameter int NCH       = 2,
    parameter int CH_W      = 1,
    parameter int OUT_W     = 20,
    parameter int OUT_SHIFT = 0
) (
    input  logic                            CLK_Filter,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CH_W-1:0]                 in_ch,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            coef_we,
    input  logic [$clog2(NTAPS/2)-1:0]      coef_addr,
    input  logic [COEF_W-1:0]               coef_data,
    output logic                            out_valid,
    output logic [CH_W-1:0]                 out_ch,
    output logic [OUT_W-1:0]                out_data
);
    localparam int NPAIR  = NTAPS / 2;
    localparam int K_W    = $clog2(NPAIR);
    localparam int TAP_W  = $clog2(NTAPS);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;
    localparam int ACC_W  = PROD_W + K_W;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MAC, S_DONE} state_t;

    state_t                              r_state, w_state_nxt;
    logic [CH_W-1:0]                     r_ch;
    logic [DATA_W-1:0]                   r_din;
    logic [K_W-1:0]                      r_k;
    logic [ACC_W-1:0]                    r_acc;
    logic [NCH-1:0][NTAPS-1:0][DATA_W-1:0] r_x;
    logic [NPAIR-1:0][COEF_W-1:0]        r_coef;
    logic                                r_out_valid;
    logic [CH_W-1:0]                     r_out_ch;
    logic [OUT_W-1:0]                    r_out_data;

    logic                                w_accept, w_ch_ok, w_addr_ok, w_last;
    logic [NTAPS-1:0][DATA_W-1:0]        w_line;
    logic [TAP_W-1:0]                    w_lo, w_hi;
    logic [PRE_W-1:0]                    w_pre;
    logic [PROD_W-1:0]                   w_prod;
    logic [ACC_W-1:0]                    w_acc_nxt, w_shift;
    logic [OUT_W-1:0]                    w_sat;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_ch_ok   = ({1'b0, in_ch} < (CH_W+1)'(NCH));
    assign w_addr_ok = ({1'b0, coef_addr} < (K_W+1)'(NPAIR));
    assign w_last    = (r_k == K_W'(NPAIR - 1));

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;

    always_comb begin
        w_line = '0;
        for (int c = 0; c < NCH; c++)
            if (r_ch == CH_W'(c)) w_line = r_x[c];
    end

    // Pair k folds the k-th newest and k-th oldest taps through the pre-adder.
    assign w_lo      = TAP_W'(r_k);
    assign w_hi      = TAP_W'(NTAPS - 1) - TAP_W'(r_k);
    assign w_pre     = {1'b0, w_line[w_lo]} + {1'b0, w_line[w_hi]};
    assign w_prod    = PROD_W'(w_pre) * PROD_W'(r_coef[r_k]);
    assign w_acc_nxt = r_acc + ACC_W'(w_prod);
    assign w_shift   = w_acc_nxt >> OUT_SHIFT;

    generate
        if (ACC_W > OUT_W) begin : g_sat
            assign w_sat = (|w_shift[ACC_W-1:OUT_W]) ? '1 : w_shift[OUT_W-1:0];
        end else begin : g_nosat
            assign w_sat = OUT_W'(w_shift);
        end
    endgenerate

    always_ff @(posedge CLK_Filter) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_ch_ok) w_state_nxt = S_SHIFT;
            S_SHIFT: w_state_nxt = S_MAC;
            S_MAC:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_Filter) begin
        if (rst) begin
            r_ch        <= '0;
            r_din       <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_coef      <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == S_IDLE && coef_we && w_addr_ok)
                r_coef[coef_addr] <= coef_data;
            for (int c = 0; c < NCH; c++)
                if (r_state == S_SHIFT && r_ch == CH_W'(c))
                    r_x[c] <= {r_x[c][NTAPS-2:0], r_din};
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_ch  <= in_ch;
                    r_din <= in_data;
                end
                S_SHIFT: begin
                    r_acc <= '0;
                    r_k   <= '0;
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + K_W'(1);
                    // Result is registered on the last MAC edge so it is visible throughout DONE.
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_out_ch    <= r_ch;
                        r_out_data  <= w_sat;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sym_mc.sv
// Bench for fir_sym_mc: four instances share one stimulus stream (default, OUT_W=16, OUT_SHIFT=4, NCH=3).
module tb_fir_sym_mc;
    logic       clk = 0, rst = 1, in_valid = 0, coef_we = 0;
    logic [1:0] in_ch = 0;
    logic [7:0] in_data = 0, coef_data = 0;
    logic [3:0] coef_addr = 0;
    logic       rdy0, rdy1, rdy2, rdy3, ov0, ov1, ov2, ov3, och0, och1, och2;
    logic [1:0] och3;
    logic [19:0] od0, od2, od3;
    logic [15:0] od1;
    int cyc = 0, nchk = 0, nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_sym_mc dut0 (.CLK_Filter(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_ch(in_ch[0]),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov0), .out_ch(och0), .out_data(od0));
    fir_sym_mc #(.OUT_W(16)) dut1 (.CLK_Filter(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_ch(in_ch[0]), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov1), .out_ch(och1), .out_data(od1));
    fir_sym_mc #(.OUT_SHIFT(4)) dut2 (.CLK_Filter(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .in_ch(in_ch[0]), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov2), .out_ch(och2), .out_data(od2));
    fir_sym_mc #(.NCH(3), .CH_W(2)) dut3 (.CLK_Filter(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
        .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov3), .out_ch(och3), .out_data(od3));

    // Reference model: plain per-channel sample history and coefficient bank.
    longint hist[3][22];
    longint cm[11];

    typedef struct { logic [1:0] ch; logic [7:0] data; longint exp; } vec_t;
    vec_t imp[25];

    function automatic longint model_acc(int c);
        longint s = 0;
        for (int k = 0; k < 11; k++) s += cm[k] * (hist[c][k] + hist[c][21-k]);
        return s;
    endfunction

    function automatic longint sat(longint a, int w, int sh);
        longint v = a >> sh;
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_push(int c, longint d);
        for (int j = 21; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = d;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) for (int j = 0; j < 22; j++) hist[c][j] = 0;
        for (int k = 0; k < 11; k++) cm[k] = 0;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic coef_write(input logic [3:0] a, input logic [7:0] d);
        coef_we = 1; coef_addr = a; coef_data = d;
        @(posedge clk); #1;
        coef_we = 0;
        if (a < 11) cm[a] = d;
        @(negedge clk);
    endtask

    // cw: 0 none, 1 coefficient write together with the sample, 2 hold a write strobe while busy.
    task automatic send(input logic [1:0] ch, input logic [7:0] d, input int cw,
                        input logic [3:0] ca, input logic [7:0] cd, output longint got);
        int t0, n;
        longint e;
        in_valid = 1; in_ch = ch; in_data = d;
        if (cw == 1) begin coef_we = 1; coef_addr = ca; coef_data = cd; end
        n = 0;
        while (!rdy0 && n < 40) begin @(negedge clk); n++; end
        chk("in_ready_wait", rdy0, 1);
        @(posedge clk); #1;
        t0 = cyc;
        in_valid = 0; in_data = 8'($urandom); in_ch = 2'($urandom_range(0, 1));
        coef_we = 0;
        if (cw == 1 && ca < 11) cm[ca] = cd;
        model_push(ch, d);
        if (cw == 2) begin coef_we = 1; coef_addr = ca; coef_data = cd; end
        @(negedge clk);
        n = 0;
        while (!ov0 && n < 30) begin @(negedge clk); n++; end
        coef_we = 0;
        e = model_acc(ch);
        chk("latency", cyc - t0, 12);
        chk("out_ch", och0, ch[0]);
        chk("out_data", od0, sat(e, 20, 0));
        chk("out_data_w16", od1, sat(e, 16, 0));
        chk("out_data_sh4", od2, sat(e, 20, 4));
        chk("out_data_nch3", od3, sat(e, 20, 0));
        got = od0;
        @(negedge clk);
        chk("out_valid_pulse", ov0, 0);
        chk("out_hold", od0, got);
    endtask

    task automatic run_impulse();
        longint g;
        for (int k = 0; k < 11; k++) coef_write(4'(k), 8'(k + 1));
        for (int i = 0; i < 25; i++) begin
            send(imp[i].ch, imp[i].data, 0, 0, 0, g);
            chk("impulse", g, imp[i].exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint g;
        int acc_idx[$];
        int seen;
        logic [7:0] lg[11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};

        for (int i = 0; i < 25; i++) begin
            imp[i].ch = 0;
            imp[i].data = (i == 0) ? 8'd1 : 8'd0;
            imp[i].exp = (i <= 10) ? i + 1 : (i <= 21) ? 22 - i : 0;
        end
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("ready_in_reset", rdy0, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("ready_after_reset", rdy0, 1);
        chk("reset_out_valid", ov0, 0);
        chk("reset_out_data", od0, 0);
        chk("reset_out_ch", och0, 0);

        run_impulse();

        // Step with legacy coefficients
        for (int k = 0; k < 11; k++) coef_write(4'(k), lg[k]);
        for (int i = 0; i < 30; i++) begin
            send(0, 255, 0, 0, 0, g);
            if (i >= 21) chk("step_settle", g, 353430);
        end
        chk("step_w16", od1, 65535);
        chk("step_sh4", od2, 22089);

        // Channel isolation
        for (int i = 0; i < 60; i++) begin
            send(2'(i % 2), (i % 2) ? 8'd0 : 8'd255, 0, 0, 0, g);
            chk("isolation", g, (i % 2) ? 0 : 353430);
        end

        // Continuous in_valid: one acceptance every 14 cycles
        in_valid = 1; in_ch = 0; in_data = 0;
        for (int i = 0; i < 42; i++) begin
            if (rdy0) begin acc_idx.push_back(i); model_push(0, 0); end
            @(negedge clk);
        end
        in_valid = 0;
        repeat (2) @(negedge clk);
        chk("busy_accepts", acc_idx.size(), 3);
        if (acc_idx.size() == 3) begin
            chk("busy_gap1", acc_idx[1] - acc_idx[0], 14);
            chk("busy_gap2", acc_idx[2] - acc_idx[1], 14);
        end

        // Write strobe held while busy must not land
        send(0, 77, 2, 0, 200, g);
        send(1, 33, 0, 0, 0, g);
        // Same-cycle write with a sample applies to that sample; out-of-range address ignored
        send(0, 90, 1, 3, 250, g);
        coef_write(13, 77);
        send(0, 12, 0, 0, 0, g);

        // Randomized traffic against the model
        for (int k = 0; k < 11; k++) coef_write(4'(k), 8'($urandom));
        for (int i = 0; i < 40; i++)
            send(2'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 4) == 0) ? 1 : 0,
                 4'($urandom_range(0, 15)), 8'($urandom), g);

        // in_ch=3 on the 3-channel instance: accepted, discarded, no result
        in_valid = 1; in_ch = 3; in_data = 200;
        @(posedge clk); #1 in_valid = 0;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) chk("badch_ready", rdy3, 1);
            if (ov3) seen++;
        end
        chk("badch_no_out", seen, 0);

        // Reset mid-MAC at k=5
        in_valid = 1; in_ch = 0; in_data = 50;
        @(posedge clk); #1 in_valid = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1;
        chk("mac_ready_low", rdy0, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("abort_out_valid", ov0, 0);
        chk("abort_out_data", od0, 0);
        chk("abort_ready", rdy0, 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (ov0) seen++;
            @(negedge clk);
        end
        chk("abort_no_out", seen, 0);
        model_clear();
        run_impulse();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
